// File: rtl/rr_decode_sched_pkg.sv
// Shared widths, FSM encoding and constants for the round-robin decode scheduler.
package rr_decode_sched_pkg;

    localparam int unsigned N_REQ  = 8;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        GAP   = 2'b10
    } state_e;

    localparam logic [N_REQ-1:0] DEC_ZERO = 8'b0;

endpackage

// File: rtl/rr_decode_sched_dec.sv
// Combinational 3-to-8 decoder with enable; output is one-hot or all zero.
module dec3to8_en
    import rr_decode_sched_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] sel_c
);

    always_comb begin
        sel_c = DEC_ZERO;
        if (en) begin
            sel_c[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decode_sched.sv
// Round-robin owner selection for one shared 8-way decoded resource, with
// bounded hold time and a one-cycle break-before-make gap between owners.
module rr_decode_sched
    import rr_decode_sched_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             busy,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

    state_e              state_q;
    state_e              state_d;
    logic [IDX_W-1:0]    last_q;
    logic [IDX_W-1:0]    last_d;
    logic [HOLD_W-1:0]   hold_q;
    logic [HOLD_W-1:0]   hold_d;
    logic [HOLD_W-1:0]   hold_inc_c;
    logic [IDX_W-1:0]    idx_d;
    logic                timeout_d;
    logic [IDX_W-1:0]    cand_c;
    logic [IDX_W-1:0]    win_c;
    logic                win_vld_c;
    logic                grant_en_c;
    logic [N_REQ-1:0]    grant_d;

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        win_c     = last_q;
        win_vld_c = 1'b0;
        cand_c    = last_q;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand_c = last_q + IDX_W'(off);
            if (!win_vld_c && req[cand_c]) begin
                win_c     = cand_c;
                win_vld_c = 1'b1;
            end
        end
    end

    assign hold_inc_c = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);

    // Next state; exits from GRANT are prioritised: enable, then drop, then hold limit.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        hold_d    = hold_q;
        idx_d     = grant_idx;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && win_vld_c) begin
                    state_d = GRANT;
                    idx_d   = win_c;
                    last_d  = win_c;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                hold_d = hold_inc_c;
                if (!en) begin
                    state_d = IDLE;
                end else if (!req[grant_idx]) begin
                    state_d = GAP;
                end else if (hold_inc_c >= HOLD_LIMIT) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign grant_en_c = (state_d == GRANT);

    dec3to8_en u_dec (
        .idx   (idx_d),
        .en    (grant_en_c),
        .sel_c (grant_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last_q    <= IDX_W'(N_REQ - 1);
            hold_q    <= '0;
            grant_idx <= '0;
            grant     <= DEC_ZERO;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            grant_idx <= idx_d;
            grant     <= grant_d;
            busy      <= grant_en_c;
            timeout   <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_decode_sched.sv
// Bench for rr_decode_sched: two instances (hold limits 4 and 3) share stimulus and
// are checked every cycle against an ownership model, plus directed literal checks.
module tb_rr_decode_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt  [2];
    logic [2:0] gidx [2];
    logic       bsy  [2];
    logic       tmo  [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rr_decode_sched #(.MAX_HOLD(4)) u_h4 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(gnt[0]), .grant_idx(gidx[0]), .busy(bsy[0]), .timeout(tmo[0])
    );

    rr_decode_sched #(.MAX_HOLD(3)) u_h3 (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .grant(gnt[1]), .grant_idx(gidx[1]), .busy(bsy[1]), .timeout(tmo[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Ownership model: who owns the resource, how long it has held, and how many
    // idle cycles must pass before the next arbitration.
    int m_limit [2] = '{4, 3};
    int m_owner [2] = '{-1, -1};
    int m_run   [2] = '{0, 0};
    int m_cool  [2] = '{0, 0};
    int m_last  [2] = '{7, 7};
    bit m_to    [2] = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            m_to[d] = 1'b0;
            if (!rst_n) begin
                m_owner[d] = -1;
                m_run[d]   = 0;
                m_cool[d]  = 0;
                m_last[d]  = 7;
            end else if (m_owner[d] >= 0) begin
                m_run[d] = m_run[d] + 1;
                if (!en) begin
                    m_owner[d] = -1;
                    m_cool[d]  = 0;
                end else if (!req[m_owner[d]]) begin
                    m_owner[d] = -1;
                    m_cool[d]  = 1;
                end else if (m_run[d] == m_limit[d]) begin
                    m_owner[d] = -1;
                    m_cool[d]  = 1;
                    m_to[d]    = 1'b1;
                end
            end else if (m_cool[d] > 0) begin
                m_cool[d] = m_cool[d] - 1;
            end else if (en && req != 8'h00) begin
                for (int o = 1; o <= 8; o++) begin
                    int c;
                    c = (m_last[d] + o) % 8;
                    if (m_owner[d] < 0 && req[c]) m_owner[d] = c;
                end
                m_last[d] = m_owner[d];
                m_run[d]  = 0;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d grant", d), 32'(gnt[d]),
                (m_owner[d] >= 0) ? (32'd1 << m_owner[d]) : 32'd0);
            chk($sformatf("dut%0d busy", d), 32'(bsy[d]), 32'(m_owner[d] >= 0));
            chk($sformatf("dut%0d timeout", d), 32'(tmo[d]), 32'(m_to[d]));
            if (m_owner[d] >= 0)
                chk($sformatf("dut%0d grant_idx", d), 32'(gidx[d]), 32'(m_owner[d]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 8'h00;
        step(2);
        rst_n = 1'b1;
    endtask

    logic [7:0] to_grant [14] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h80,
                                  8'h80, 8'h80, 8'h80, 8'h00, 8'h00, 8'h01, 8'h01};
    logic       to_pulse [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        int cnt;
        #1;
        chk("reset grant", 32'(gnt[0]), 32'h0);
        chk("reset busy", 32'(bsy[0]), 32'h0);
        chk("reset timeout", 32'(tmo[0]), 32'h0);
        chk("reset idx", 32'(gidx[0]), 32'h0);
        do_reset();

        // Single request: one-cycle latency, drop clears next cycle.
        en  = 1'b1;
        req = 8'h04;
        step(1);
        chk("single grant", 32'(gnt[0]), 32'h04);
        chk("single idx", 32'(gidx[0]), 32'd2);
        chk("single busy", 32'(bsy[0]), 32'd1);
        req = 8'h00;
        step(1);
        chk("single drop grant", 32'(gnt[0]), 32'h00);
        step(2);

        // Fairness: all request, each owner holds two cycles then drops and re-raises.
        do_reset();
        en  = 1'b1;
        req = 8'hFF;
        step(1);
        for (int k = 0; k <= 8; k++) begin
            chk("rr order", 32'(gidx[0]), 32'(k % 8));
            chk("rr busy", 32'(bsy[0]), 32'd1);
            if (k < 8) begin
                step(1);
                req[k % 8] = 1'b0;
                step(1);
                req[k % 8] = 1'b1;
                cnt = 1;
                step(1);
                while (!bsy[0] && cnt < 10) begin
                    cnt++;
                    step(1);
                end
                chk("rr gap cycles", 32'(cnt), 32'd2);
            end
        end

        // Timeout alternation between bits 0 and 7 with hold limit 4.
        do_reset();
        en  = 1'b1;
        req = 8'h81;
        for (int i = 0; i < 14; i++) begin
            step(1);
            chk($sformatf("timeout grant[%0d]", i), 32'(gnt[0]), 32'(to_grant[i]));
            chk($sformatf("timeout pulse[%0d]", i), 32'(tmo[0]), 32'(to_pulse[i]));
        end

        // Enable drop mid-grant, then wrap-around arbitration from last+1.
        do_reset();
        en  = 1'b1;
        req = 8'h20;
        step(1);
        chk("en grant5", 32'(gnt[0]), 32'h20);
        en = 1'b0;
        step(1);
        chk("en off grant", 32'(gnt[0]), 32'h00);
        chk("en off timeout", 32'(tmo[0]), 32'h0);
        step(2);
        en  = 1'b1;
        req = 8'h21;
        step(1);
        chk("en back grant", 32'(gnt[0]), 32'h01);
        chk("en back idx", 32'(gidx[0]), 32'd0);

        // Asynchronous reset between edges while granting.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async grant h4", 32'(gnt[0]), 32'h00);
        chk("async busy h4", 32'(bsy[0]), 32'h0);
        chk("async grant h3", 32'(gnt[1]), 32'h00);
        chk("async busy h3", 32'(bsy[1]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 8'h02;
        step(1);
        chk("post reset grant", 32'(gnt[0]), 32'h02);
        chk("post reset idx", 32'(gidx[0]), 32'd1);

        // Drop in the same cycle the hold limit (3) is reached: no timeout.
        do_reset();
        en  = 1'b1;
        req = 8'h08;
        step(3);
        chk("simul last grant", 32'(gnt[1]), 32'h08);
        req = 8'h00;
        step(1);
        chk("simul grant", 32'(gnt[1]), 32'h00);
        chk("simul timeout", 32'(tmo[1]), 32'h0);
        step(1);
        chk("simul timeout late", 32'(tmo[1]), 32'h0);
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
